// File: rtl/fcode_lockdet.sv
// Frequency-code lock detector: tracks the averaged code until it has been
// stable for LOCK_CNT consecutive samples, then freezes it for the DCO.
// Lock is dropped after UNLOCK_CNT consecutive out-of-tolerance samples.
module fcode_lockdet #(
   parameter int W          = 8,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] code_in,
   output logic [W-1:0] code_out,
   output logic         locked,
   output logic         lock_pulse,
   output logic         unlock_pulse,
   output logic [1:0]   state,
   output logic [7:0]   unlock_cnt
);

   // Counters sized to hold exactly LOCK_CNT-1 / UNLOCK_CNT-1; the terminal
   // value triggers the transition instead of incrementing, so they never wrap.
   localparam int SW = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
   localparam int MW = (UNLOCK_CNT > 2) ? $clog2(UNLOCK_CNT) : 1;

   localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_CNT - 1);
   localparam logic [MW-1:0] MISS_LAST   = MW'(UNLOCK_CNT - 1);
   localparam logic [W:0]    TOL_V       = (W+1)'(TOL);
   localparam logic [W-1:0]  RST_CODE    = W'(8);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  ref_q, ref_d;
   logic [W-1:0]  code_out_q, code_out_d;
   logic [SW-1:0] stable_q, stable_d;
   logic [MW-1:0] miss_q, miss_d;
   logic [7:0]    unlock_cnt_q, unlock_cnt_d;
   logic          lock_pulse_q, lock_pulse_d;
   logic          unlock_pulse_q, unlock_pulse_d;

   logic [W:0]    dev;
   logic          in_tol;

   // Absolute deviation of the incoming code from the reference, one bit
   // wider than the code and subtracted in the non-negative direction.
   always_comb begin
      if (code_in >= ref_q) dev = {1'b0, code_in} - {1'b0, ref_q};
      else                  dev = {1'b0, ref_q} - {1'b0, code_in};
      in_tol = (dev <= TOL_V);
   end

   // Next-state and datapath decisions; en low overrides every transition.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d        = state_q;
      ref_d          = ref_q;
      code_out_d     = code_in;
      stable_d       = stable_q;
      miss_d         = miss_q;
      unlock_cnt_d   = unlock_cnt_q;
      lock_pulse_d   = 1'b0;
      unlock_pulse_d = 1'b0;

      if (!en) begin
         // Leaving for IDLE: output resumes tracking the input immediately.
         state_d  = ST_IDLE;
         stable_d = '0;
         miss_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d  = ST_ACQ;
               ref_d    = code_in;
               stable_d = '0;
               miss_d   = '0;
            end
            ST_ACQ: begin
               if (in_tol) begin
                  if (stable_q == STABLE_LAST) begin
                     state_d      = ST_LOCKED;
                     code_out_d   = ref_q;
                     lock_pulse_d = 1'b1;
                     stable_d     = '0;
                     miss_d       = '0;
                  end else begin
                     stable_d = stable_q + 1'b1;
                  end
               end else begin
                  ref_d    = code_in;
                  stable_d = '0;
               end
            end
            ST_LOCKED: begin
               // Frozen output holds the old reference, also on the unlock edge.
               code_out_d = ref_q;
               if (in_tol) begin
                  miss_d = '0;
               end else if (miss_q == MISS_LAST) begin
                  state_d        = ST_ACQ;
                  ref_d          = code_in;
                  stable_d       = '0;
                  miss_d         = '0;
                  unlock_pulse_d = 1'b1;
                  if (unlock_cnt_q != 8'hFF) unlock_cnt_d = unlock_cnt_q + 8'd1;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               stable_d = '0;
               miss_d   = '0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q        <= ST_IDLE;
         ref_q          <= RST_CODE;
         code_out_q     <= RST_CODE;
         stable_q       <= '0;
         miss_q         <= '0;
         unlock_cnt_q   <= '0;
         lock_pulse_q   <= 1'b0;
         unlock_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ref_q          <= ref_d;
         code_out_q     <= code_out_d;
         stable_q       <= stable_d;
         miss_q         <= miss_d;
         unlock_cnt_q   <= unlock_cnt_d;
         lock_pulse_q   <= lock_pulse_d;
         unlock_pulse_q <= unlock_pulse_d;
      end
   end

   assign code_out     = code_out_q;
   assign locked       = (state_q == ST_LOCKED);
   assign lock_pulse   = lock_pulse_q;
   assign unlock_pulse = unlock_pulse_q;
   assign state        = state_q;
   assign unlock_cnt   = unlock_cnt_q;

endmodule

// File: tb/tb_fcode_lockdet.sv
// Bench for fcode_lockdet: directed scenarios plus a randomized phase, all
// compared cycle by cycle against a run-length reference model.
module tb_fcode_lockdet;

   localparam int W          = 8;
   localparam int TOL        = 1;
   localparam int LOCK_CNT   = 16;
   localparam int UNLOCK_CNT = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] code_in;
   logic [W-1:0] code_out;
   logic         locked;
   logic         lock_pulse;
   logic         unlock_pulse;
   logic [1:0]   state;
   logic [7:0]   unlock_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: state 0 IDLE, 1 ACQ, 2 LOCKED; run/misses count samples.
   int m_state, m_ref, m_out, m_run, m_miss, m_ucnt;
   bit m_lp, m_up;

   fcode_lockdet #(
      .W(W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .code_in      (code_in),
      .code_out     (code_out),
      .locked       (locked),
      .lock_pulse   (lock_pulse),
      .unlock_pulse (unlock_pulse),
      .state        (state),
      .unlock_cnt   (unlock_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one clock edge's worth of the rules to the model.
   task automatic model_step();
      int d;
      m_lp = 1'b0;
      m_up = 1'b0;
      if (rst) begin
         m_state = 0; m_ref = 8; m_out = 8; m_run = 0; m_miss = 0; m_ucnt = 0;
      end else if (!en) begin
         m_state = 0; m_run = 0; m_miss = 0; m_out = int'(code_in);
      end else begin
         d = int'(code_in) - m_ref;
         if (d < 0) d = -d;
         case (m_state)
            0: begin
               m_out = int'(code_in); m_ref = int'(code_in);
               m_run = 0; m_miss = 0; m_state = 1;
            end
            1: begin
               m_out = int'(code_in);
               if (d <= TOL) begin
                  m_run++;
                  if (m_run == LOCK_CNT) begin
                     m_state = 2; m_out = m_ref; m_lp = 1'b1; m_run = 0;
                  end
               end else begin
                  m_ref = int'(code_in); m_run = 0;
               end
            end
            default: begin
               m_out = m_ref;
               if (d <= TOL) begin
                  m_miss = 0;
               end else begin
                  m_miss++;
                  if (m_miss == UNLOCK_CNT) begin
                     m_state = 1; m_ref = int'(code_in); m_miss = 0; m_run = 0;
                     m_up = 1'b1;
                     if (m_ucnt < 255) m_ucnt++;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic compare_all();
      check("state",        32'(state),        32'(m_state));
      check("code_out",     32'(code_out),     32'(m_out));
      check("locked",       32'(locked),       32'(m_state == 2));
      check("lock_pulse",   32'(lock_pulse),   32'(m_lp));
      check("unlock_pulse", 32'(unlock_pulse), 32'(m_up));
      check("unlock_cnt",   32'(unlock_cnt),   32'(m_ucnt));
      check("ref",          32'(dut.ref_q),    32'(m_ref));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic drive(input bit r, input bit e, input int c);
      rst     = r;
      en      = e;
      code_in = c[7:0];
   endtask

   initial begin
      int base;
      int c;
      drive(1'b1, 1'b0, 0);

      // Reset state
      repeat (2) tick();
      check("rst_state",    32'(state),      0);
      check("rst_code_out", 32'(code_out),   8);
      check("rst_ucnt",     32'(unlock_cnt), 0);

      // Constant code: ACQ one edge later, lock exactly 16 edges after that
      drive(1'b0, 1'b1, 5);
      tick();
      check("acq_entry", 32'(state), 1);
      repeat (LOCK_CNT - 1) tick();
      check("lock_not_early", 32'(locked), 0);
      tick();
      check("lock_on_time", 32'(locked), 1);
      check("lock_pulse_on", 32'(lock_pulse), 1);
      check("lock_code", 32'(code_out), 5);
      tick();
      check("lock_pulse_once", 32'(lock_pulse), 0);

      // Three misses then a hit keep lock; the miss count restarts
      drive(1'b0, 1'b1, 8); repeat (3) tick();
      drive(1'b0, 1'b1, 5); tick();
      check("miss3_locked", 32'(state), 2);
      check("miss3_code", 32'(code_out), 5);
      drive(1'b0, 1'b1, 8); repeat (3) tick();
      check("miss_cleared", 32'(state), 2);
      tick();
      check("unlock_pulse_on", 32'(unlock_pulse), 1);
      check("unlock_state", 32'(state), 1);
      check("unlock_ref", 32'(dut.ref_q), 8);
      check("unlock_cnt1", 32'(unlock_cnt), 1);

      // Alternating 5/6 within tolerance locks
      drive(1'b0, 1'b1, 5); tick();
      for (int i = 0; i < LOCK_CNT; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0) ? 6 : 5);
         tick();
         if (i == LOCK_CNT - 2) check("alt_not_early", 32'(locked), 0);
      end
      check("alt_locked", 32'(locked), 1);

      // Outlier at stable count 10 restarts acquisition around the new value
      drive(1'b0, 1'b0, 5); tick();
      drive(1'b0, 1'b1, 5); tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0) ? 6 : 5);
         tick();
      end
      drive(1'b0, 1'b1, 8); tick();
      check("outlier_ref", 32'(dut.ref_q), 8);
      for (int i = 0; i < LOCK_CNT; i++) begin
         drive(1'b0, 1'b1, int'($urandom_range(9, 7)));
         tick();
         if (i == LOCK_CNT - 2) check("outlier_not_early", 32'(locked), 0);
      end
      check("outlier_locked", 32'(locked), 1);

      // en dropped on the edge of the final stable sample
      drive(1'b0, 1'b0, 5); tick();
      drive(1'b0, 1'b1, 5); tick();
      repeat (LOCK_CNT - 1) tick();
      drive(1'b0, 1'b0, 5); tick();
      check("en_prio_state", 32'(state), 0);
      check("en_prio_locked", 32'(locked), 0);
      check("en_prio_pulse", 32'(lock_pulse), 0);

      // Deviation boundaries without wrap
      drive(1'b0, 1'b1, 1); tick();
      drive(1'b0, 1'b1, 0); tick();
      check("bnd_0_vs_1", 32'(dut.ref_q), 1);
      drive(1'b0, 1'b0, 0); tick();
      drive(1'b0, 1'b1, 254); tick();
      drive(1'b0, 1'b1, 255); tick();
      check("bnd_255_vs_254", 32'(dut.ref_q), 254);
      drive(1'b0, 1'b0, 0); tick();
      drive(1'b0, 1'b1, 255); tick();
      drive(1'b0, 1'b1, 0); tick();
      check("bnd_0_vs_255", 32'(dut.ref_q), 0);

      // 260 lock/unlock cycles saturate the unlock counter
      for (int k = 0; k < 260; k++) begin
         drive(1'b0, 1'b1, 5);
         repeat (LOCK_CNT + 1) tick();
         drive(1'b0, 1'b1, 200);
         repeat (UNLOCK_CNT) tick();
      end
      check("ucnt_saturated", 32'(unlock_cnt), 255);

      // Reset while locked discards everything
      drive(1'b0, 1'b1, 5);
      repeat (LOCK_CNT + 1) tick();
      check("pre_rst_locked", 32'(locked), 1);
      drive(1'b1, 1'b1, 5); tick();
      check("rst_lk_state", 32'(state), 0);
      check("rst_lk_code", 32'(code_out), 8);
      check("rst_lk_locked", 32'(locked), 0);
      check("rst_lk_ucnt", 32'(unlock_cnt), 0);
      drive(1'b0, 1'b1, 5); tick();
      check("rst_restart", 32'(state), 1);

      // Randomized phase: slowly wandering code with jitter and outliers
      base = 100;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) base = int'($urandom_range(0, 255));
         c = base + int'($urandom_range(0, 2)) - 1;
         if ($urandom_range(0, 29) == 0) c = int'($urandom_range(0, 255));
         if (c < 0) c = 0;
         if (c > 255) c = 255;
         drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 59) != 0), c);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
